// File: rtl/me_pe_driver.sv
// Sequencer for one PE chain of the integer motion-estimation array: loads the
// current-block slots, then walks a snake-order search window slot by slot.
module me_pe_driver #(
    parameter int PIXEL     = 8,
    parameter int CHAIN_LEN = 8,
    parameter int COLS      = 8,
    parameter int ROWS      = 8
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic                    start,
    input  logic [2:0]              num_cb_m1,
    input  logic                    cur_valid,
    input  logic [PIXEL-1:0]        cur_data,
    output logic                    cur_ready,
    input  logic                    ref_valid,
    input  logic [PIXEL-1:0]        ref_data,
    output logic                    ref_ready,
    output logic [PIXEL-1:0]        in_curr,
    output logic                    in_curr_enable,
    output logic [2:0]              CB_select,
    output logic                    change_ref,
    output logic [1:0]              ref_input_Control,
    output logic [PIXEL-1:0]        ref_edge,
    output logic [2:0]              abs_Control,
    output logic                    abs_valid,
    output logic [$clog2(COLS)-1:0] pos_x,
    output logic [$clog2(ROWS)-1:0] pos_y,
    output logic                    busy,
    output logic                    done
);

    localparam int PW = $clog2(CHAIN_LEN);
    localparam int XW = $clog2(COLS);
    localparam int YW = $clog2(ROWS);
    localparam logic [PW-1:0] PIX_MAX = PW'(CHAIN_LEN - 1);
    localparam logic [XW-1:0] X_MAX   = XW'(COLS - 1);
    localparam logic [YW-1:0] Y_MAX   = YW'(ROWS - 1);

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        LOAD  = 3'd1,
        SHIFT = 3'd2,
        CMP   = 3'd3,
        DONE  = 3'd4
    } state_t;

    state_t            state_q, state_d;
    logic [2:0]        ncb_q, ncb_d;
    logic [2:0]        cb_q, cb_d;
    logic [PW-1:0]     pix_q, pix_d;
    logic [XW-1:0]     col_q, col_d;
    logic [YW-1:0]     row_q, row_d;
    logic [2:0]        slot_q, slot_d;

    logic [PIXEL-1:0]  in_curr_q, in_curr_d;
    logic              en_q, en_d;
    logic [2:0]        cb_sel_q, cb_sel_d;
    logic              change_ref_q, change_ref_d;
    logic [1:0]        ref_ctrl_q, ref_ctrl_d;
    logic [PIXEL-1:0]  ref_edge_q, ref_edge_d;
    logic [2:0]        abs_ctrl_q, abs_ctrl_d;
    logic              abs_valid_q, abs_valid_d;
    logic [XW-1:0]     pos_x_q, pos_x_d;
    logic [YW-1:0]     pos_y_q, pos_y_d;
    logic              busy_q, busy_d;
    logic              done_q, done_d;

    always_comb begin
        state_d      = state_q;
        ncb_d        = ncb_q;
        cb_d         = cb_q;
        pix_d        = pix_q;
        col_d        = col_q;
        row_d        = row_q;
        slot_d       = slot_q;
        in_curr_d    = in_curr_q;
        en_d         = 1'b0;
        cb_sel_d     = cb_sel_q;
        change_ref_d = 1'b0;
        ref_ctrl_d   = ref_ctrl_q;
        ref_edge_d   = ref_edge_q;
        abs_ctrl_d   = abs_ctrl_q;
        abs_valid_d  = 1'b0;
        pos_x_d      = pos_x_q;
        pos_y_d      = pos_y_q;

        case (state_q)
            IDLE: begin
                if (start) begin
                    ncb_d   = num_cb_m1;
                    cb_d    = '0;
                    pix_d   = '0;
                    col_d   = '0;
                    row_d   = '0;
                    slot_d  = '0;
                    state_d = LOAD;
                end
            end
            LOAD: begin
                if (cur_valid) begin
                    in_curr_d = cur_data;
                    en_d      = 1'b1;
                    cb_sel_d  = cb_q;
                    if (pix_q == PIX_MAX) begin
                        pix_d = '0;
                        if (cb_q == ncb_q) begin
                            state_d = SHIFT;
                        end else begin
                            cb_d = cb_q + 3'd1;
                        end
                    end else begin
                        pix_d = pix_q + PW'(1);
                    end
                end
            end
            SHIFT: begin
                if (ref_valid) begin
                    change_ref_d = 1'b1;
                    ref_edge_d   = ref_data;
                    // First column steps down a row; odd rows walk right-to-left.
                    if (col_q == '0) begin
                        ref_ctrl_d = 2'b01;
                    end else if (row_q[0]) begin
                        ref_ctrl_d = 2'b10;
                    end else begin
                        ref_ctrl_d = 2'b00;
                    end
                    slot_d  = '0;
                    state_d = CMP;
                end
            end
            CMP: begin
                abs_ctrl_d  = slot_q;
                abs_valid_d = 1'b1;
                pos_x_d     = row_q[0] ? (X_MAX - col_q) : col_q;
                pos_y_d     = row_q;
                if (slot_q == ncb_q) begin
                    slot_d  = '0;
                    state_d = SHIFT;
                    if (col_q == X_MAX) begin
                        col_d = '0;
                        if (row_q == Y_MAX) begin
                            state_d = DONE;
                        end else begin
                            row_d = row_q + YW'(1);
                        end
                    end else begin
                        col_d = col_q + XW'(1);
                    end
                end else begin
                    slot_d = slot_q + 3'd1;
                end
            end
            DONE: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase

        busy_d = (state_d != IDLE);
        done_d = (state_q == DONE);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= IDLE;
            ncb_q        <= '0;
            cb_q         <= '0;
            pix_q        <= '0;
            col_q        <= '0;
            row_q        <= '0;
            slot_q       <= '0;
            in_curr_q    <= '0;
            en_q         <= 1'b0;
            cb_sel_q     <= '0;
            change_ref_q <= 1'b0;
            ref_ctrl_q   <= '0;
            ref_edge_q   <= '0;
            abs_ctrl_q   <= '0;
            abs_valid_q  <= 1'b0;
            pos_x_q      <= '0;
            pos_y_q      <= '0;
            busy_q       <= 1'b0;
            done_q       <= 1'b0;
        end else begin
            state_q      <= state_d;
            ncb_q        <= ncb_d;
            cb_q         <= cb_d;
            pix_q        <= pix_d;
            col_q        <= col_d;
            row_q        <= row_d;
            slot_q       <= slot_d;
            in_curr_q    <= in_curr_d;
            en_q         <= en_d;
            cb_sel_q     <= cb_sel_d;
            change_ref_q <= change_ref_d;
            ref_ctrl_q   <= ref_ctrl_d;
            ref_edge_q   <= ref_edge_d;
            abs_ctrl_q   <= abs_ctrl_d;
            abs_valid_q  <= abs_valid_d;
            pos_x_q      <= pos_x_d;
            pos_y_q      <= pos_y_d;
            busy_q       <= busy_d;
            done_q       <= done_d;
        end
    end

    assign cur_ready         = (state_q == LOAD);
    assign ref_ready         = (state_q == SHIFT);
    assign in_curr           = in_curr_q;
    assign in_curr_enable    = en_q;
    assign CB_select         = cb_sel_q;
    assign change_ref        = change_ref_q;
    assign ref_input_Control = ref_ctrl_q;
    assign ref_edge          = ref_edge_q;
    assign abs_Control       = abs_ctrl_q;
    assign abs_valid         = abs_valid_q;
    assign pos_x             = pos_x_q;
    assign pos_y             = pos_y_q;
    assign busy              = busy_q;
    assign done              = done_q;

endmodule
